// File: rtl/float_subtractor_seq.sv
// float_subtractor_seq: multi-cycle IEEE-754 a - b with 1-bit-per-cycle align/normalize, FTZ.
// Define FSUB_RNE_EN for round-to-nearest-even; otherwise rounds toward zero.
module float_subtractor_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int MAX_ALIGN = 27
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int M = MAN_W + 4;
   localparam int SW = MAN_W + 5;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state;
   logic [M-1:0] x, y;
   logic [SW-1:0] s;
   logic [EXP_W:0] ex;
   logic [EXP_W-1:0] rem;
   logic sx, sub;
   // b's sign is inverted at decode so the datapath only ever adds signed magnitudes
   logic sa, sb, a_big, far, nan, special;
   logic [EXP_W-1:0] ea, eb, diff;
   logic [MAN_W-1:0] fa, fb;
   logic [M-1:0] ma, mb, my;
   assign sa = a[W-1];
   assign sb = ~b[W-1];
   assign ea = a[W-2:MAN_W];
   assign eb = b[W-2:MAN_W];
   assign fa = a[MAN_W-1:0];
   assign fb = b[MAN_W-1:0];
   assign ma = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
   assign mb = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
   assign a_big = {ea, fa} >= {eb, fb};
   assign diff = a_big ? ea - eb : eb - ea;
   assign my = a_big ? mb : ma;
   assign far = 32'(diff) > MAX_ALIGN;
   assign special = ea == EMAX || eb == EMAX;
   assign nan = (ea == EMAX && fa != '0) || (eb == EMAX && fb != '0) || (ea == EMAX && eb == EMAX && sa != sb);
   assign in_ready = state == IDLE;
   logic inc;
   logic [MAN_W:0] rnd;
   logic [EXP_W:0] er;
`ifdef FSUB_RNE_EN
   assign inc = s[2] & (s[1] | s[0] | s[3]);
`else
   assign inc = 1'b0;
`endif
   assign rnd = {1'b0, s[SW-3:3]} + (MAN_W+1)'(inc);
   assign er = ex + (EXP_W+1)'(rnd[MAN_W]);
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         out_valid <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x <= a_big ? ma : mb;
               y <= far ? M'(|my) : my;
               rem <= far ? '0 : diff;
               ex <= {1'b0, a_big ? ea : eb};
               sx <= a_big ? sa : sb;
               sub <= sa != sb;
               if (special) begin
                  result <= nan ? QNAN : {(ea == EMAX) ? sa : sb, EMAX, {MAN_W{1'b0}}};
                  out_valid <= 1'b1;
                  state <= DONE;
               end else state <= ALIGN;
            end
            ALIGN: if (rem == '0) state <= ADD;
            else begin
               y <= {1'b0, y[M-1:2], y[1] | y[0]};
               rem <= rem - 1'b1;
            end
            ADD: begin
               s <= sub ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
               state <= NORM;
            end
            NORM: if (s[SW-1]) begin
               s <= {1'b0, s[SW-1:2], s[1] | s[0]};
               ex <= ex + 1'b1;
               state <= ROUND;
            end else if (s == '0) begin
               sx <= 1'b0;
               state <= ROUND;
            end else if (!s[SW-2]) begin
               // an exponent that would fall below 1 means a denormal result: flush
               if (ex[EXP_W:1] == '0) begin
                  s <= '0;
                  state <= ROUND;
               end else begin
                  s <= s << 1;
                  ex <= ex - 1'b1;
               end
            end else state <= ROUND;
            ROUND: begin
               result <= !s[SW-2] ? {sx, {(W-1){1'b0}}}
                  : er >= {1'b0, EMAX} ? {sx, EMAX, {MAN_W{1'b0}}}
                  : {sx, er[EXP_W-1:0], rnd[MAN_W-1:0]};
               out_valid <= 1'b1;
               state <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_float_subtractor_seq.sv
// tb_float_subtractor_seq: directed and random checks of float_subtractor_seq
// against an exact big-integer reference model.
module tb_float_subtractor_seq;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic [31:0] a = '0, b = '0, result;
   int errors = 0, checks = 0;
   bit rne;

   float_subtractor_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   always #5 clk = ~clk;

   // exact a - b on scaled integers, then FTZ/round/overflow on the exact value
   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input bit mode_rne);
      logic signed [299:0] va, vb, d;
      logic [299:0] mag, rmd, half;
      logic [24:0] man;
      logic [7:0] ex, ey;
      bit sx, sy;
      int p, e;
      sx = x[31];
      sy = ~y[31];
      ex = x[30:23];
      ey = y[30:23];
      if (ex == 8'hFF || ey == 8'hFF) begin
         if ((ex == 8'hFF && x[22:0] != 0) || (ey == 8'hFF && y[22:0] != 0) || (ex == 8'hFF && ey == 8'hFF && sx != sy))
            return 32'h7FC00000;
         return {(ex == 8'hFF) ? sx : sy, 8'hFF, 23'h0};
      end
      va = (ex == 0) ? '0 : 300'({1'b1, x[22:0]}) << ex;
      vb = (ey == 0) ? '0 : 300'({1'b1, y[22:0]}) << ey;
      d = (sx ? -va : va) + (sy ? -vb : vb);
      if (d == 0) return 32'h0;
      mag = (d < 0) ? -d : d;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = p - 23;
      if (e < 1) return {d < 0, 31'h0};
      man = 25'(mag >> (p - 23));
      rmd = mag & ((300'b1 << (p - 23)) - 300'b1);
      half = 300'b1 << (p - 24);
      if (mode_rne && (rmd > half || (rmd == half && man[0]))) man = man + 25'd1;
      if (man[24]) begin
         man = man >> 1;
         e++;
      end
      if (e >= 255) return {d < 0, 8'hFF, 23'h0};
      return {d < 0, 8'(e), man[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // issue one op from IDLE, wait (bounded) for out_valid, accept it
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, output logic [31:0] r, output int lat);
      int n;
      a = ia;
      b = ib;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         lat++;
         n++;
      end
      check("op_done_in_time", 32'(out_valid), 32'd1);
      r = result;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r, ra, rb;
      int lat, n, ea, eb, mode;
      bit seen;
`ifdef FSUB_RNE_EN
      rne = 1'b1;
`else
      rne = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", result, 32'h0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      run_op(32'h40400000, 32'h3F800000, r, lat);
      check("3_minus_1", r, 32'h40000000);
      check("3_minus_1_latency", lat, 6);
      check("single_pulse", 32'(out_valid), 32'd0);

      run_op(32'h3F800000, 32'h3F800000, r, lat);
      check("1_minus_1", r, 32'h00000000);
      run_op(32'h3F800000, 32'hBF800000, r, lat);
      check("1_minus_neg1", r, 32'h40000000);
      run_op(32'h3F800000, 32'hB4400000, r, lat);
      check("round_tie", r, rne ? 32'h3F800002 : 32'h3F800001);
      run_op(32'h7F800000, 32'h7F800000, r, lat);
      check("inf_minus_inf", r, 32'h7FC00000);
      run_op(32'h7F800000, 32'h3F800000, r, lat);
      check("inf_minus_1", r, 32'h7F800000);
      check("special_latency", lat, 1);
      run_op(32'h7F7FFFFF, 32'hFF7FFFFF, r, lat);
      check("overflow_inf", r, 32'h7F800000);
      run_op(32'h00800001, 32'h00800000, r, lat);
      check("underflow_ftz", r, 32'h00000000);
      run_op(32'h3F800000, 32'h00000000, r, lat);
      check("minus_zero_exact", r, 32'h3F800000);

      a = 32'h40400000;
      b = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("stall_reach_done", 32'(out_valid), 32'd1);
      a = 32'h3F800000;
      b = 32'h3F800000;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("stall_result", result, 32'h40000000);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("stall_release_valid", 32'(out_valid), 32'd0);
      check("stall_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("stall_no_ghost_op", 32'(in_ready), 32'd1);

      a = 32'h4B000000;
      b = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_output", 32'(seen), 32'd0);

      for (int i = 0; i < 300; i++) begin
         ea = $urandom_range(1, 254);
         mode = $urandom_range(0, 4);
         eb = mode == 0 ? ea + int'($urandom_range(0, 6)) - 3
            : mode == 1 ? int'($urandom_range(0, 255))
            : mode == 2 ? ea - int'($urandom_range(20, 32)) : ea;
         if (eb < 0) eb = 0;
         if (eb > 255) eb = 255;
         ra = {1'($urandom), 8'(ea), 23'($urandom)};
         rb = mode == 3 ? {1'($urandom), 8'(eb), ra[22:0] ^ 23'($urandom_range(0, 15))}
            : {1'($urandom), 8'(eb), 23'($urandom)};
         if (mode == 4)
            rb = {1'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00,
                  ($urandom_range(0, 1) == 1) ? 23'h0 : 23'($urandom)};
         if ($urandom_range(0, 1) == 1) begin
            r = ra;
            ra = rb;
            rb = r;
         end
         run_op(ra, rb, r, lat);
         check($sformatf("rand%0d a=%h b=%h", i, ra, rb), r, model(ra, rb, rne));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
